// File: rtl/turf_wb_initiator.sv
// WISHBONE classic single-transfer initiator: command stream in, response stream out,
// bounded rty reissue; bus timeout built only when WB_INITIATOR_TIMEOUT_EN is defined.
module turf_wb_initiator #(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 1023,
   parameter int unsigned RTY_LIMIT  = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
   input  logic                    cmd_we_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic [1:0]              rsp_status_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i
);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("turf_wb_initiator: TIMEOUT must be in 1..65535");
   end
   if (RTY_LIMIT > 15) begin : g_bad_rty_limit
      $error("turf_wb_initiator: RTY_LIMIT must be in 0..15");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_e;
   typedef enum logic [1:0] {
      RSP_ACK = 2'b00,
      RSP_ERR = 2'b01,
      RSP_RTY = 2'b10,
      RSP_TMO = 2'b11
   } rsp_status_e;

   state_e                  state_q;
   logic [3:0]              rty_cnt_q;
   logic                    cmd_ready_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_dat_q;
   rsp_status_e             rsp_status_q;
   logic                    wb_cyc_q;
   logic                    wb_stb_q;
   logic                    wb_we_q;
   logic [ADDR_WIDTH-1:0]   wb_adr_q;
   logic [DATA_WIDTH-1:0]   wb_dat_q;
   logic [DATA_WIDTH/8-1:0] wb_sel_q;

   logic                    tmo_hit;
   logic                    bus_done;
   logic                    bus_retry;
   rsp_status_e             bus_status;
   logic [DATA_WIDTH-1:0]   bus_dat;

`ifdef WB_INITIATOR_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;
   assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT));
`else
   assign tmo_hit = 1'b0;
`endif

   // Outcome of one BUS cycle; priority err > ack > rty > timeout
   always_comb begin
      bus_done   = 1'b1;
      bus_retry  = 1'b0;
      bus_status = RSP_ACK;
      bus_dat    = '0;
      if (wb_err_i) begin
         bus_status = RSP_ERR;
      end else if (wb_ack_i) begin
         bus_dat = wb_we_q ? '0 : wb_dat_i;
      end else if (wb_rty_i) begin
         if (rty_cnt_q == 4'(RTY_LIMIT)) begin
            bus_status = RSP_RTY;
         end else begin
            bus_done  = 1'b0;
            bus_retry = 1'b1;
         end
      end else if (tmo_hit) begin
         bus_status = RSP_TMO;
      end else begin
         bus_done = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         rty_cnt_q    <= '0;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= RSP_ACK;
         wb_cyc_q     <= 1'b0;
         wb_stb_q     <= 1'b0;
         wb_we_q      <= 1'b0;
         wb_adr_q     <= '0;
         wb_dat_q     <= '0;
         wb_sel_q     <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
         tmo_cnt_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_ready_q && cmd_valid_i) begin
                  cmd_ready_q <= 1'b0;
                  wb_cyc_q    <= 1'b1;
                  wb_stb_q    <= 1'b1;
                  wb_we_q     <= cmd_we_i;
                  wb_adr_q    <= cmd_adr_i;
                  wb_dat_q    <= cmd_dat_i;
                  wb_sel_q    <= cmd_sel_i;
                  rty_cnt_q   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                  tmo_cnt_q   <= '0;
`endif
                  state_q     <= S_BUS;
               end
            end
            S_BUS: begin
               if (bus_done) begin
                  wb_cyc_q     <= 1'b0;
                  wb_stb_q     <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_dat_q    <= bus_dat;
                  rsp_status_q <= bus_status;
                  state_q      <= S_RESP;
               end else if (bus_retry) begin
                  wb_cyc_q  <= 1'b0;
                  wb_stb_q  <= 1'b0;
                  rty_cnt_q <= rty_cnt_q + 4'd1;
                  state_q   <= S_BACKOFF;
               end else begin
`ifdef WB_INITIATOR_TIMEOUT_EN
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
               end
            end
            S_BACKOFF: begin
               wb_cyc_q  <= 1'b1;
               wb_stb_q  <= 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
               state_q   <= S_BUS;
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready_o  = cmd_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_status_o = rsp_status_q;
   assign wb_cyc_o     = wb_cyc_q;
   assign wb_stb_o     = wb_stb_q;
   assign wb_we_o      = wb_we_q;
   assign wb_adr_o     = wb_adr_q;
   assign wb_dat_o     = wb_dat_q;
   assign wb_sel_o     = wb_sel_q;

endmodule
